// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing generator with a clock-enable pixel
//            divider and an optional tick-aligned delay on sync/blank.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int PIPE_DELAY = 0,
    parameter int COORD_W    = 10
) (
    input  logic               clock_50,
    input  logic               reset_key,
    input  logic               enable,
    output logic               pixel_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               line_start,
    output logic               frame_start
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] c_H_LAST  = COORD_W'(c_H_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_V_LAST  = COORD_W'(c_V_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_H_VIS   = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] c_V_VIS   = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] c_HS_BEG  = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] c_HS_END  = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] c_VS_BEG  = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] c_VS_END  = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic               c_HS_ON   = 1'(HS_POL);
    localparam logic               c_VS_ON   = 1'(VS_POL);
    localparam logic               c_HS_OFF  = ~c_HS_ON;
    localparam logic               c_VS_OFF  = ~c_VS_ON;

    logic [c_DIV_W-1:0] r_div;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_vid;
    logic               r_hs;
    logic               r_vs;
    logic               r_ls;
    logic               r_fs;

    logic               w_tick;
    logic               w_x_wrap;
    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;
    logic               w_vid_next;
    logic               w_hs_act;
    logic               w_vs_act;
    logic [2:0]         w_dly_out;

    // Tick is gated by reset so CLK_DIV=1 does not show a tick while held in reset.
    assign w_tick = reset_key & enable & (r_div == c_DIV_MAX);

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_div <= '0;
        end else if (!enable || (r_div == c_DIV_MAX)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_x_wrap   = (r_x == c_H_LAST);
        w_x_next   = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_next   = r_y;
        if (w_x_wrap) begin
            w_y_next = (r_y == c_V_LAST) ? '0 : r_y + 1'b1;
        end
        w_vid_next = (w_x_next < c_H_VIS) && (w_y_next < c_V_VIS);
        w_hs_act   = (w_x_next >= c_HS_BEG) && (w_x_next < c_HS_END);
        w_vs_act   = (w_y_next >= c_VS_BEG) && (w_y_next < c_VS_END);
    end

    // Flags are decoded from the count being loaded so they line up with pixel_x/pixel_y.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_x   <= '0;
            r_y   <= '0;
            r_vid <= 1'b0;
            r_hs  <= c_HS_OFF;
            r_vs  <= c_VS_OFF;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_ls <= 1'b0;
            r_fs <= 1'b0;
            if (w_tick) begin
                r_x   <= w_x_next;
                r_y   <= w_y_next;
                r_vid <= w_vid_next;
                r_hs  <= w_hs_act ? c_HS_ON : c_HS_OFF;
                r_vs  <= w_vs_act ? c_VS_ON : c_VS_OFF;
                r_ls  <= (w_x_next == '0);
                r_fs  <= (w_x_next == '0) && (w_y_next == '0);
            end
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_direct
            assign w_dly_out = {r_vid, r_hs, r_vs};
        end else begin : g_pipe
            logic [2:0] r_stage [PIPE_DELAY];

            always_ff @(posedge clock_50 or negedge reset_key) begin
                if (!reset_key) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_stage[i] <= {1'b0, c_HS_OFF, c_VS_OFF};
                    end
                end else if (w_tick) begin
                    r_stage[0] <= {r_vid, r_hs, r_vs};
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign w_dly_out = r_stage[PIPE_DELAY-1];
        end
    endgenerate

    assign pixel_tick  = w_tick;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign video_on    = w_dly_out[2];
    assign vga_hs      = w_dly_out[1];
    assign vga_vs      = w_dly_out[0];
    assign line_start  = r_ls;
    assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed bench for vga_timing_gen across four parameter sets.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    // a: defaults, b: PIPE_DELAY=2, c: inverted polarity CLK_DIV=1 short frame, d: tiny raster
    logic       tick_a, vo_a, hs_a, vs_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       tick_b, vo_b, hs_b, vs_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       tick_c, vo_c, hs_c, vs_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;
    logic       tick_d, vo_d, hs_d, vs_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;

    vga_timing_gen u_a (
        .clock_50(clk), .reset_key(rst_n), .enable(en), .pixel_tick(tick_a),
        .pixel_x(x_a), .pixel_y(y_a), .video_on(vo_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(.PIPE_DELAY(2)) u_b (
        .clock_50(clk), .reset_key(rst_n), .enable(en), .pixel_tick(tick_b),
        .pixel_x(x_b), .pixel_y(y_b), .video_on(vo_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(.CLK_DIV(1), .HS_POL(1), .VS_POL(1),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_c (
        .clock_50(clk), .reset_key(rst_n), .enable(en), .pixel_tick(tick_c),
        .pixel_x(x_c), .pixel_y(y_c), .video_on(vo_c), .vga_hs(hs_c), .vga_vs(vs_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_d (
        .clock_50(clk), .reset_key(rst_n), .enable(en), .pixel_tick(tick_d),
        .pixel_x(x_d), .pixel_y(y_d), .video_on(vo_d), .vga_hs(hs_d), .vga_vs(vs_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int ls_a_n = 0, ls_a_c0 = 0, ls_a_c1 = 0, ls_a_dbl = 0;
    int hs_a_low = 0, hs_a_fx = -1, hs_a_fc = -1, hs_a_lx = -1;
    int hs_b_fc = -1, hs_b_fx = -1, vo_b_fx = -1;
    int tick_c_low = 0, ls_c_n = 0, ls_c_c0 = 0, ls_c_c1 = 0, hs_c_hi = 0;
    int fs_c_n = 0, fs_c_c0 = 0, fs_c_c1 = 0, vs_c_hi = 0;
    int fs_d_n = 0, fs_d_c0 = 0, fs_d_c1 = 0, vs_d_low = 0, vo_d_ticks = 0;
    int hold_ticks = 0, hold_ls = 0, found = 0;
    logic ls_a_prev = 1'b0, vo_b_prev = 1'b0;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x_a",    int'(x_a),    0);
        chk("rst_y_a",    int'(y_a),    0);
        chk("rst_tick_a", int'(tick_a), 0);
        chk("rst_tick_c", int'(tick_c), 0);
        chk("rst_hs_a",   int'(hs_a),   1);
        chk("rst_vs_a",   int'(vs_a),   1);
        chk("rst_vo_a",   int'(vo_a),   0);
        chk("rst_ls_a",   int'(ls_a),   0);
        chk("rst_hs_b",   int'(hs_b),   1);
        chk("rst_hs_c",   int'(hs_c),   0);
        chk("rst_vs_c",   int'(vs_c),   0);

        rst_n = 1'b1;
        #1;
        chk("clk1_tick_a", int'(tick_a), 0);
        chk("clk1_tick_c", int'(tick_c), 1);
        @(negedge clk);
        chk("clk2_tick_a", int'(tick_a), 1);
        chk("clk2_x_a",    int'(x_a),    0);
        chk("clk2_x_c",    int'(x_c),    1);
        @(negedge clk);
        chk("clk3_tick_a", int'(tick_a), 0);
        chk("clk3_x_a",    int'(x_a),    1);
        chk("clk3_vo_a",   int'(vo_a),   1);
        chk("clk3_ls_a",   int'(ls_a),   0);

        for (int i = 0; i < 14000; i++) begin
            @(negedge clk);
            if (ls_a) begin
                if (ls_a_n == 0) ls_a_c0 = i;
                else if (ls_a_n == 1) ls_a_c1 = i;
                ls_a_n++;
            end
            if (ls_a && ls_a_prev) ls_a_dbl++;
            ls_a_prev = ls_a;
            if (ls_a_n == 0 && !hs_a) begin
                hs_a_low++;
                hs_a_lx = int'(x_a);
                if (hs_a_fc < 0) begin
                    hs_a_fc = i;
                    hs_a_fx = int'(x_a);
                end
            end
            if (!hs_b && hs_b_fc < 0) begin
                hs_b_fc = i;
                hs_b_fx = int'(x_a);
            end
            if (vo_b_prev && !vo_b && vo_b_fx < 0) vo_b_fx = int'(x_a);
            vo_b_prev = vo_b;

            if (!tick_c) tick_c_low++;
            if (ls_c) begin
                if (ls_c_n == 0) ls_c_c0 = i;
                else if (ls_c_n == 1) ls_c_c1 = i;
                ls_c_n++;
            end
            if (ls_c_n == 0 && hs_c) hs_c_hi++;
            if (fs_c) begin
                if (fs_c_n == 0) fs_c_c0 = i;
                else if (fs_c_n == 1) fs_c_c1 = i;
                fs_c_n++;
            end
            if (fs_c_n == 1 && vs_c) vs_c_hi++;

            if (fs_d) begin
                if (fs_d_n == 0) fs_d_c0 = i;
                else if (fs_d_n == 1) fs_d_c1 = i;
                fs_d_n++;
            end
            if (fs_d_n == 1) begin
                if (!vs_d) vs_d_low++;
                if (vo_d && tick_d) vo_d_ticks++;
            end
        end

        chk("hs_a_low_clks", hs_a_low, 192);
        chk("hs_a_first_x",  hs_a_fx,  656);
        chk("hs_a_last_x",   hs_a_lx,  751);
        chk("ls_a_period",   ls_a_c1 - ls_a_c0, 1600);
        chk("ls_a_width",    ls_a_dbl, 0);
        chk("hs_b_lag_clks", hs_b_fc - hs_a_fc, 4);
        chk("hs_b_fall_x",   hs_b_fx,  658);
        chk("vo_b_fall_x",   vo_b_fx,  642);
        chk("tick_c_low",    tick_c_low, 0);
        chk("ls_c_period",   ls_c_c1 - ls_c_c0, 800);
        chk("hs_c_high",     hs_c_hi,  96);
        chk("fs_c_period",   fs_c_c1 - fs_c_c0, 6400);
        chk("vs_c_high",     vs_c_hi,  1600);
        chk("fs_d_period",   fs_d_c1 - fs_d_c0, 240);
        chk("vs_d_low",      vs_d_low, 60);
        chk("vo_d_ticks",    vo_d_ticks, 32);

        // Hold the raster at x=300 for 100 clocks.
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(negedge clk);
            if (x_a == 10'd300) found = 1;
        end
        chk("wait_x300", found, 1);
        en = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tick_a || tick_c) hold_ticks++;
            if (ls_a || ls_c) hold_ls++;
        end
        chk("hold_ticks", hold_ticks, 0);
        chk("hold_ls",    hold_ls,    0);
        chk("hold_x_a",   int'(x_a),  300);
        en = 1'b1;
        #1;
        chk("resume_tick0", int'(tick_a), 0);
        @(negedge clk);
        chk("resume_tick1", int'(tick_a), 1);
        chk("resume_x300",  int'(x_a),    300);
        @(negedge clk);
        chk("resume_x301",  int'(x_a),    301);

        // Asynchronous reset in the middle of both sync pulses of the tiny raster.
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge clk);
            if (x_d == 10'd12 && y_d == 10'd5) found = 1;
        end
        chk("wait_d_sync", found, 1);
        chk("pre_hs_d", int'(hs_d), 0);
        chk("pre_vs_d", int'(vs_d), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_x_d",    int'(x_d),    0);
        chk("arst_y_d",    int'(y_d),    0);
        chk("arst_hs_d",   int'(hs_d),   1);
        chk("arst_vs_d",   int'(vs_d),   1);
        chk("arst_x_a",    int'(x_a),    0);
        chk("arst_vo_a",   int'(vo_a),   0);
        chk("arst_hs_b",   int'(hs_b),   1);
        chk("arst_tick_c", int'(tick_c), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("exit_ls_d", int'(ls_d), 0);
        chk("exit_fs_d", int'(fs_d), 0);
        @(negedge clk);
        chk("exit_tick_d", int'(tick_d), 1);
        chk("exit_x_d0",   int'(x_d),    0);
        @(negedge clk);
        chk("exit_x_d1",   int'(x_d),    1);
        chk("exit_y_d",    int'(y_d),    0);
        chk("exit_fs_d2",  int'(fs_d),   0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
